imem_loader: RTL
================

# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle RISC-V processor. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them into the processor's instruction memory. It holds the core in reset until the image is fully written, then releases it so execution starts at PC 0 with the new program in place.

## Interface
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2^ADDR_W words
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, RUN, ERR
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction-memory write enable, one cycle per word
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  instruction word to write
- core_reset  output  1  drives processor reset; high in every state except RUN
- busy  output  1  high in HDR0, HDR1, DATA, CSUM, FLUSH
- done  output  1  one-cycle pulse in the first RUN cycle
- err  output  1  high while in ERR

## Operation
- Stream format: 16-bit word count N (low byte first), then 4·N data bytes, each word little-endian (byte 0 = bits 7:0).
- Byte transfer occurs on a rising edge where in_valid && in_ready. in_ready = 1 only in HDR0, HDR1, DATA, CSUM.
- States: IDLE, HDR0, HDR1, DATA, CSUM, FLUSH, RUN, ERR.
- IDLE/RUN/ERR --start--> HDR0; clears word index, byte index, checksum.
- HDR0 --byte--> HDR1 (latch N[7:0]).
- HDR1 --byte--> latch N[15:8]; N > DEPTH -> ERR; N == 0 -> FLUSH (CSUM if checksum enabled); else DATA.
- DATA: 2-bit byte index, 3-byte assembly buffer. On the 4th byte: register imem_we=1, imem_addr=word index, imem_wdata={in_data, buf[23:0]}; word index increments. After word N-1: next state FLUSH (CSUM if enabled); otherwise stays in DATA.
- FLUSH: one cycle, in_ready=0, lets the final write retire; always -> RUN.
- RUN: core_reset=0; stays until start or reset.
- ERR: core_reset=1, err=1; no writes; exits only via start or reset.
- start while busy is ignored. in_valid while in_ready=0 is ignored (not consumed).
- Word-index counter is ADDR_W+1 bits; N == DEPTH is legal and fills memory exactly, no wrap.

## Timing
- Reset values: state IDLE, core_reset=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0.
- imem_we asserts in the cycle after the edge accepting a word's 4th byte, for exactly one cycle; back-to-back words give imem_we pulses 4 cycles apart minimum.
- Last write cycle is the FLUSH cycle (or first CSUM cycle); core_reset falls on the edge ending FLUSH, so the core's first fetch sees all written words.
- Minimum load latency from start: 1 + 2 + 4N + 1 cycles to RUN with full-rate in_valid.
- reset mid-load: IDLE next cycle, partial word discarded, imem_we=0, no spurious write; memory contents already written are left as-is.
- start in RUN re-asserts core_reset on the next edge.

## Configuration
- LOADER_CHECKSUM_EN defined: one trailer byte follows the data (also when N=0); it must equal XOR of all data bytes. CSUM state accepts it; match -> FLUSH -> RUN, mismatch -> ERR (words already written remain, core stays in reset).
- Undefined: no trailer, no CSUM state; DATA/HDR1 go directly to FLUSH.

## Test plan
- Assert reset 2 cycles -> all outputs at reset values; core_reset=1, in_ready=0.
- start, stream 02 00 13 00 10 00 93 00 20 00 at full rate -> writes addr0=0x00100013, addr1=0x00200093; done pulses once; core_reset=0 from the cycle after FLUSH.
- Same stream with in_valid low every other cycle -> identical writes and data; only cycle count changes; no extra imem_we.
- ADDR_W=8, header 01 01 (N=257) -> ERR, err=1, no imem_we, core_reset=1; start then valid image -> RUN.
- reset after 2 data bytes of word 0 -> IDLE, no write; fresh load of N=1, 33 00 00 00 -> addr0=0x00000033.
- With LOADER_CHECKSUM_EN: N=1 data 13 00 10 00 trailer 03 -> RUN; trailer 04 -> ERR, err=1, core_reset=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time byte-stream loader: assembles little-endian words into instruction memory
// and holds the core in reset until the image is written. Optional trailer check: LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_FLUSH, S_RUN, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_FLUSH;
`endif

  state_t              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [ADDR_W:0]     widx_q, widx_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [23:0]         buf_q, buf_d;
  logic [7:0]          csum_q, csum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                in_ready_q, in_ready_d;
  logic                core_reset_q, core_reset_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                xfer;
  logic [15:0]         n_full;
  logic                last_word;

  assign xfer      = in_valid && in_ready_q;
  assign n_full    = {in_data, n_q[7:0]};
  assign last_word = (16'(widx_q) + 16'd1) == n_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    buf_d    = buf_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          widx_d  = '0;
          bidx_d  = 2'd0;
          csum_d  = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          n_d[7:0] = in_data;
          state_d  = S_HDR1;
        end else begin
          state_d = S_HDR0;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d = n_full;
          if (17'(n_full) > DEPTH) begin
            state_d = S_ERR;
          end else if (n_full == 16'd0) begin
            state_d = S_AFTER_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_HDR1;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ in_data;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: buf_d[7:0]   = in_data;
            2'd1: buf_d[15:8]  = in_data;
            2'd2: buf_d[23:16] = in_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = {in_data, buf_q};
              widx_d  = widx_q + (ADDR_W+1)'(1);
              state_d = last_word ? S_AFTER_DATA : S_DATA;
            end
          endcase
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? S_FLUSH : S_ERR;
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_FLUSH: begin
        state_d = S_RUN;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d   = state_d inside {S_HDR0, S_HDR1, S_DATA, S_CSUM};
    busy_d       = state_d inside {S_HDR0, S_HDR1, S_DATA, S_CSUM, S_FLUSH};
    core_reset_d = state_d != S_RUN;
    err_d        = state_d == S_ERR;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= 16'd0;
      widx_q       <= '0;
      bidx_q       <= 2'd0;
      buf_q        <= 24'd0;
      csum_q       <= 8'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      buf_q        <= buf_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      in_ready_q   <= in_ready_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
